branch_resolve: RTL

- EX-stage branch resolution unit for the RV32I core.
- Consumes the 32-bit magnitude comparator's Less result and selects the comparator mode from funct3.
- Decides the branch outcome, checks it against the fetch-stage static prediction, and issues a registered PC redirect plus a multi-cycle flush of wrong-path instructions.
- Keeps saturating branch and mispredict counters for performance debug.

---
 rtl/branch_resolve.sv | 103 ++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decides the conditional branch outcome, checks the
// fetch-stage static prediction, and issues a registered redirect plus a timed flush.
module branch_resolve #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic             pred_taken,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             uMod,
  input  logic             Less,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             br_taken,
  output logic             br_illegal,
  output logic             br_misalign,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [3:0]  flushCnt;
  logic        accept;
  logic        isEq;
  logic        isTaken;
  logic        isIllegal;
  logic        isMispred;
  logic        isMisalign;
  logic [31:0] targetPc;
  logic [31:0] fallPc;

  // The comparator's signedness follows funct3[1] (BLTU/BGEU).
  assign uMod = br_funct3[1];

  assign flush  = (flushCnt != '0);
  assign accept = br_valid & ~stall & ~flush;

  assign isEq     = (rs1_data == rs2_data);
  assign targetPc = br_pc + br_imm;
  assign fallPc   = br_pc + 32'd4;

  always_comb begin
    isTaken   = 1'b0;
    isIllegal = 1'b0;
    case (br_funct3)
      3'b000:         isTaken = isEq;
      3'b001:         isTaken = ~isEq;
      3'b100, 3'b110: isTaken = Less;
      3'b101, 3'b111: isTaken = ~Less;
      default:        isIllegal = 1'b1;
    endcase
  end

  assign isMispred  = (isTaken != pred_taken);
  assign isMisalign = isTaken & (targetPc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      br_taken    <= 1'b0;
      br_illegal  <= 1'b0;
      br_misalign <= 1'b0;
      br_cnt      <= '0;
      mispred_cnt <= '0;
      flushCnt    <= '0;
    end else begin
      redirect    <= 1'b0;
      br_illegal  <= 1'b0;
      br_misalign <= 1'b0;

      if (flush && !stall)
        flushCnt <= flushCnt - 4'd1;

      // accept implies flush is low, so a reload never races the decrement
      if (accept) begin
        br_taken   <= isTaken;
        br_illegal <= isIllegal;
        if (br_cnt != '1)
          br_cnt <= br_cnt + CNT_W'(1);

        if (isMisalign) begin
          br_misalign <= 1'b1;
          flushCnt    <= 4'(FLUSH_CYC);
        end else if (isMispred) begin
          redirect    <= 1'b1;
          redirect_pc <= isTaken ? targetPc : fallPc;
          flushCnt    <= 4'(FLUSH_CYC);
          if (mispred_cnt != '1)
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
